// File: rtl/moore_detector_ctrl_if.sv
// Serial-sample bus between the stimulus source, the Ej1 state controller and the display logic.
// inputValid qualifies inputX and inputClr acts alone; there is no ready, so every cycle with inputValid=1 is a consumed sample.
interface moore_detector_ctrl_if #(
    parameter int COUNT_W = 8
);
    logic               inputValid;
    logic               inputX;
    logic               inputClr;
    logic               outputy1;
    logic               outputy2;
    logic               outputZ;
    logic [COUNT_W-1:0] outputCount;
    logic               outputSat;

    modport master (
        output inputValid, inputX, inputClr,
        input  outputy1, outputy2, outputZ, outputCount, outputSat
    );

    modport slave (
        input  inputValid, inputX, inputClr,
        output outputy1, outputy2, outputZ, outputCount, outputSat
    );
endinterface

// File: rtl/moore_detector_ctrl.sv
// Moore state controller for the Ej1 3-bit sequence detector: owns {y1,y2}, drives Z and a
// saturating match counter. The transition table is built at elaboration from PATTERN/OVERLAP.
module moore_detector_ctrl #(
    parameter logic [2:0] PATTERN = 3'b101,
    parameter int         OVERLAP = 1,
    parameter int         COUNT_W = 8
) (
    input  logic                 inputClk,
    input  logic                 inputR,
    moore_detector_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    // Longest prefix of PATTERN that is a suffix of (matched prefix of length k, then x).
    function automatic logic [1:0] next_fn(input int k_in, input logic x);
        int         k;
        logic [3:0] seq;
        logic [3:0] suffix;
        logic [3:0] prefix;
        logic [1:0] res;
        k      = (k_in == 3 && OVERLAP == 0) ? 0 : k_in;
        seq    = {1'b0, PATTERN} >> (3 - k);
        seq    = {seq[2:0], x};
        res    = 2'd0;
        for (int j = 1; j <= 3; j++) begin
            suffix = seq & ((4'd1 << j) - 4'd1);
            prefix = {1'b0, PATTERN} >> (3 - j);
            if (j <= k + 1 && suffix == prefix) begin
                res = 2'(j);
            end
        end
        return res;
    endfunction

    logic [1:0] next_tbl [8];

    for (genvar g = 0; g < 8; g++) begin : g_tbl
        assign next_tbl[g] = next_fn(g >> 1, (g % 2) != 0);
    end

    state_t             state;
    logic               z;
    logic [COUNT_W-1:0] count;
    logic               sat;

    logic [1:0]         nxt;
    logic               match;
    logic [COUNT_W-1:0] cnt_base;
    logic               sat_base;
    logic [COUNT_W-1:0] count_nxt;
    logic               sat_nxt;

    assign nxt   = next_tbl[{state, bus.inputX}];
    assign match = bus.inputValid && (nxt == S3);

    // Clear is applied before the match increment, so a match on a clear edge yields 1.
    always_comb begin
        cnt_base  = bus.inputClr ? '0 : count;
        sat_base  = bus.inputClr ? 1'b0 : sat;
        count_nxt = cnt_base;
        sat_nxt   = sat_base;
        if (match && cnt_base != CNT_MAX) begin
            count_nxt = cnt_base + 1'b1;
            sat_nxt   = sat_base | (count_nxt == CNT_MAX);
        end
    end

    always_ff @(posedge inputClk) begin
        if (inputR) begin
            state <= S0;
            z     <= 1'b0;
            count <= '0;
            sat   <= 1'b0;
        end else begin
            if (bus.inputValid) begin
                state <= state_t'(nxt);
                z     <= (nxt == S3);
            end
            count <= count_nxt;
            sat   <= sat_nxt;
        end
    end

    assign bus.outputy1    = state[1];
    assign bus.outputy2    = state[0];
    assign bus.outputZ     = z;
    assign bus.outputCount = count;
    assign bus.outputSat   = sat;

endmodule
